// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding in front of the ALU.
// Supports stall (hold, with operand refresh), flush (bubble) and a saturating bubble counter.
module id_ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              InValid,
  input  logic [3:0]        ALUOperationIn,
  input  logic [DATA_W-1:0] RsData,
  input  logic [DATA_W-1:0] RtData,
  input  logic [DATA_W-1:0] Immediate,
  input  logic [4:0]        ShamtIn,
  input  logic [4:0]        RsAddr,
  input  logic [4:0]        RtAddr,
  input  logic [4:0]        RdAddr,
  input  logic              ALUSrc,
  input  logic              RegWriteIn,
  input  logic              ExMemRegWrite,
  input  logic [4:0]        ExMemRd,
  input  logic [DATA_W-1:0] ExMemResult,
  input  logic              MemWbRegWrite,
  input  logic [4:0]        MemWbRd,
  input  logic [DATA_W-1:0] MemWbResult,
  output logic [3:0]        ALUOperation,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [4:0]        shamt,
  output logic [4:0]        RdOut,
  output logic              RegWriteOut,
  output logic              OutValid,
  output logic [CNT_W-1:0]  BubbleCount
);

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic [3:0]        alu_op;
    logic              alu_src;
    logic [4:0]        rs_addr;
    logic [4:0]        rt_addr;
    logic [4:0]        rd_addr;
    logic [4:0]        shamt;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
  } stage_t;

  stage_t            stage_q, stage_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
  logic              ex_mem_fwd_ok, mem_wb_fwd_ok;
  logic [DATA_W-1:0] fwd_a, fwd_rt;

  // Register 0 is hardwired to zero, so a write to it is never a forwarding source.
  assign ex_mem_fwd_ok = ExMemRegWrite && (ExMemRd != 5'd0);
  assign mem_wb_fwd_ok = MemWbRegWrite && (MemWbRd != 5'd0);

  always_comb begin
    fwd_a = stage_q.rs_data;
    if (ex_mem_fwd_ok && ExMemRd == stage_q.rs_addr)      fwd_a = ExMemResult;
    else if (mem_wb_fwd_ok && MemWbRd == stage_q.rs_addr) fwd_a = MemWbResult;
  end

  always_comb begin
    fwd_rt = stage_q.rt_data;
    if (ex_mem_fwd_ok && ExMemRd == stage_q.rt_addr)      fwd_rt = ExMemResult;
    else if (mem_wb_fwd_ok && MemWbRd == stage_q.rt_addr) fwd_rt = MemWbResult;
  end

  // NOTE: defaulting every always_comb output to its held value first keeps this block latch-free.
  always_comb begin
    stage_d      = stage_q;
    bubble_cnt_d = bubble_cnt_q;
    if (flush) begin
      stage_d = '0;
      if (bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end else if (stall) begin
      // Refresh operands so a forward that retires while we wait is captured.
      stage_d.rs_data = fwd_a;
      stage_d.rt_data = fwd_rt;
    end else begin
      stage_d.valid     = InValid;
      stage_d.reg_write = RegWriteIn && InValid;
      stage_d.alu_op    = ALUOperationIn;
      stage_d.alu_src   = ALUSrc;
      stage_d.rs_addr   = RsAddr;
      stage_d.rt_addr   = RtAddr;
      stage_d.rd_addr   = RdAddr;
      stage_d.shamt     = ShamtIn;
      stage_d.rs_data   = RsData;
      stage_d.rt_data   = RtData;
      stage_d.imm       = Immediate;
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset is sampled on the edge and overrides all.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q      <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stage_q      <= stage_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ALUOperation = stage_q.alu_op;
  assign A            = fwd_a;
  assign B            = stage_q.alu_src ? stage_q.imm : fwd_rt;
  assign shamt        = stage_q.shamt;
  assign RdOut        = stage_q.rd_addr;
  assign RegWriteOut  = stage_q.reg_write;
  assign OutValid     = stage_q.valid;
  assign BubbleCount  = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed scenarios plus randomized traffic
// compared against a behavioural stage model; a CNT_W=2 copy exercises counter saturation.
module tb_id_ex_operand_stage;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset, stall, flush, InValid, ALUSrc, RegWriteIn;
  logic [3:0]        ALUOperationIn;
  logic [DATA_W-1:0] RsData, RtData, Immediate;
  logic [4:0]        ShamtIn, RsAddr, RtAddr, RdAddr;
  logic              ExMemRegWrite, MemWbRegWrite;
  logic [4:0]        ExMemRd, MemWbRd;
  logic [DATA_W-1:0] ExMemResult, MemWbResult;

  logic [3:0]        ALUOperation, sat_op;
  logic [DATA_W-1:0] A, B, sat_a, sat_b;
  logic [4:0]        shamt, RdOut, sat_shamt, sat_rd;
  logic              RegWriteOut, OutValid, sat_regwr, sat_valid;
  logic [15:0]       BubbleCount;
  logic [1:0]        sat_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.DATA_W(DATA_W), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .InValid(InValid),
    .ALUOperationIn(ALUOperationIn), .RsData(RsData), .RtData(RtData), .Immediate(Immediate),
    .ShamtIn(ShamtIn), .RsAddr(RsAddr), .RtAddr(RtAddr), .RdAddr(RdAddr), .ALUSrc(ALUSrc),
    .RegWriteIn(RegWriteIn), .ExMemRegWrite(ExMemRegWrite), .ExMemRd(ExMemRd),
    .ExMemResult(ExMemResult), .MemWbRegWrite(MemWbRegWrite), .MemWbRd(MemWbRd),
    .MemWbResult(MemWbResult), .ALUOperation(ALUOperation), .A(A), .B(B), .shamt(shamt),
    .RdOut(RdOut), .RegWriteOut(RegWriteOut), .OutValid(OutValid), .BubbleCount(BubbleCount)
  );

  id_ex_operand_stage #(.DATA_W(DATA_W), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .InValid(InValid),
    .ALUOperationIn(ALUOperationIn), .RsData(RsData), .RtData(RtData), .Immediate(Immediate),
    .ShamtIn(ShamtIn), .RsAddr(RsAddr), .RtAddr(RtAddr), .RdAddr(RdAddr), .ALUSrc(ALUSrc),
    .RegWriteIn(RegWriteIn), .ExMemRegWrite(ExMemRegWrite), .ExMemRd(ExMemRd),
    .ExMemResult(ExMemResult), .MemWbRegWrite(MemWbRegWrite), .MemWbRd(MemWbRd),
    .MemWbResult(MemWbResult), .ALUOperation(sat_op), .A(sat_a), .B(sat_b), .shamt(sat_shamt),
    .RdOut(sat_rd), .RegWriteOut(sat_regwr), .OutValid(sat_valid), .BubbleCount(sat_count)
  );

  // Behavioural model: the instruction currently held in the stage, plus flush tallies.
  typedef struct {
    bit          valid, reg_write, alu_src;
    int unsigned op, rs, rt, rd, sh;
    int unsigned rs_val, rt_val, imm;
  } instr_t;

  instr_t      m;
  int unsigned m_bubbles, m_bubbles_sat;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned operand_value(input int unsigned addr, input int unsigned held);
    if (addr != 0 && ExMemRegWrite && ExMemRd == addr) return ExMemResult;
    if (addr != 0 && MemWbRegWrite && MemWbRd == addr) return MemWbResult;
    return held;
  endfunction

  task automatic model_edge();
    int unsigned a_now, rt_now;
    if (reset) begin
      m = '{default: 0};
      m_bubbles = 0;
      m_bubbles_sat = 0;
    end else if (flush) begin
      m = '{default: 0};
      if (m_bubbles < 65535) m_bubbles++;
      if (m_bubbles_sat < 3) m_bubbles_sat++;
    end else if (stall) begin
      a_now    = operand_value(m.rs, m.rs_val);
      rt_now   = operand_value(m.rt, m.rt_val);
      m.rs_val = a_now;
      m.rt_val = rt_now;
    end else begin
      m.valid     = InValid;
      m.reg_write = RegWriteIn && InValid;
      m.alu_src   = ALUSrc;
      m.op = ALUOperationIn; m.rs = RsAddr; m.rt = RtAddr; m.rd = RdAddr; m.sh = ShamtIn;
      m.rs_val = RsData; m.rt_val = RtData; m.imm = Immediate;
    end
  endtask

  // Inputs change only at the falling edge; the model follows each rising edge.
  task automatic apply_edge();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic check_outputs(input string tag);
    int unsigned exp_b;
    #1;
    exp_b = m.alu_src ? m.imm : operand_value(m.rt, m.rt_val);
    check({tag, "_valid"}, OutValid, m.valid);
    check({tag, "_regwr"}, RegWriteOut, m.reg_write);
    check({tag, "_op"}, ALUOperation, m.op);
    check({tag, "_A"}, A, operand_value(m.rs, m.rs_val));
    check({tag, "_B"}, B, exp_b);
    check({tag, "_shamt"}, shamt, m.sh);
    check({tag, "_rd"}, RdOut, m.rd);
    check({tag, "_bubbles"}, BubbleCount, m_bubbles);
    check({tag, "_bubbles_sat"}, sat_count, m_bubbles_sat);
  endtask

  task automatic clear_inputs();
    stall = 0; flush = 0; InValid = 0; ALUSrc = 0; RegWriteIn = 0;
    ALUOperationIn = 0; RsData = 0; RtData = 0; Immediate = 0;
    ShamtIn = 0; RsAddr = 0; RtAddr = 0; RdAddr = 0;
    ExMemRegWrite = 0; ExMemRd = 0; ExMemResult = 0;
    MemWbRegWrite = 0; MemWbRd = 0; MemWbResult = 0;
  endtask

  task automatic drive_random();
    reset          = ($urandom_range(0, 39) == 0);
    flush          = ($urandom_range(0, 9) == 0);
    stall          = ($urandom_range(0, 4) == 0);
    InValid        = $urandom_range(0, 1);
    RegWriteIn     = $urandom_range(0, 1);
    ALUSrc         = $urandom_range(0, 1);
    ALUOperationIn = 4'($urandom_range(0, 6));
    RsData = $urandom; RtData = $urandom; Immediate = $urandom;
    ShamtIn = 5'($urandom); RdAddr = 5'($urandom);
    RsAddr  = 5'($urandom_range(0, 3));
    RtAddr  = 5'($urandom_range(0, 3));
    ExMemRegWrite = $urandom_range(0, 1);
    ExMemRd       = 5'($urandom_range(0, 3));
    ExMemResult   = $urandom;
    MemWbRegWrite = $urandom_range(0, 1);
    MemWbRd       = 5'($urandom_range(0, 3));
    MemWbResult   = $urandom;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    reset = 1;
    m = '{default: 0};
    m_bubbles = 0;
    m_bubbles_sat = 0;
    apply_edge();
    reset = 0;
    check_outputs("reset");
    check("reset_A_const", A, 0);

    // Plain ADD capture, no forwarding sources active.
    InValid = 1; RegWriteIn = 1; ALUOperationIn = 4'd3;
    RsData = 5; RtData = 7; RsAddr = 1; RtAddr = 2; RdAddr = 3;
    apply_edge();
    check_outputs("add");
    check("add_A_const", A, 5);
    check("add_B_const", B, 7);
    check("add_op_const", ALUOperation, 3);

    // Both forwarding sources hit Rs=8: EX/MEM must win, then MEM/WB alone.
    RsAddr = 8; RsData = 32'h99;
    apply_edge();
    ExMemRegWrite = 1; ExMemRd = 8; ExMemResult = 32'h11;
    MemWbRegWrite = 1; MemWbRd = 8; MemWbResult = 32'h22;
    check_outputs("fwd_prio");
    check("fwd_prio_A_const", A, 32'h11);
    ExMemRegWrite = 0;
    check_outputs("fwd_memwb");
    check("fwd_memwb_A_const", A, 32'h22);

    // Writes to register 0 are never forwarded.
    MemWbRegWrite = 0;
    RtAddr = 0; RtData = 32'h44; ALUSrc = 0;
    apply_edge();
    ExMemRegWrite = 1; ExMemRd = 0; ExMemResult = 32'hFFFF_FFFF;
    check_outputs("r0");
    check("r0_B_const", B, 32'h44);

    // Stall with a MEM/WB forward present only during the first stalled cycle.
    ExMemRegWrite = 0;
    RsAddr = 9; RsData = 32'h10; ALUOperationIn = 4'd5; ShamtIn = 5'd4; ALUSrc = 1; Immediate = 32'h77;
    apply_edge();
    stall = 1;
    MemWbRegWrite = 1; MemWbRd = 9; MemWbResult = 32'h33;
    RsData = 32'hDEAD; ALUOperationIn = 4'd2; ShamtIn = 5'd17; Immediate = 32'h55;
    check_outputs("stall_c1");
    apply_edge();
    MemWbRegWrite = 0;
    check_outputs("stall_c2");
    check("stall_c2_A_const", A, 32'h33);
    apply_edge();
    stall = 0;
    check_outputs("stall_rel");
    check("stall_rel_A_const", A, 32'h33);
    check("stall_rel_op_const", ALUOperation, 5);
    check("stall_rel_shamt_const", shamt, 4);
    check("stall_rel_B_const", B, 32'h77);

    // Flush beats stall; forwarding a write to r0 must not disturb the bubble.
    flush = 1; stall = 1; InValid = 1;
    apply_edge();
    ExMemRegWrite = 1; ExMemRd = 0; ExMemResult = 32'hFFFF_FFFF;
    check_outputs("flush");
    check("flush_valid_const", OutValid, 0);
    check("flush_A_const", A, 0);
    check("flush_B_const", B, 0);
    check("flush_cnt_const", BubbleCount, 1);

    // Four more flushes: the 2-bit counter pins at 3, the 16-bit one reaches 5.
    stall = 0;
    for (int i = 0; i < 4; i++) apply_edge();
    check_outputs("sat");
    check("sat_cnt2_const", sat_count, 3);
    check("sat_cnt16_const", BubbleCount, 5);

    // Reset in the middle of flush and stall clears everything.
    reset = 1; flush = 1; stall = 1;
    apply_edge();
    reset = 0; flush = 0; stall = 0;
    check_outputs("rst_mid");
    check("rst_mid_cnt_const", BubbleCount, 0);
    check("rst_mid_cnt2_const", sat_count, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive_random();
      apply_edge();
      drive_random();
      reset = 0;
      check_outputs("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
